// File: rtl/xorshift_matrix_filler.sv
// xorshift_matrix_filler: fills an R x C matrix row-major with signed random elements in [min,max],
// consuming NUM_LANES xorshift32 words per fetch and writing through a valid/ready port.
module xorshift_matrix_filler #(
  parameter int NUM_LANES  = 4,
  parameter int ELEM_WIDTH = 16,
  parameter int MAX_DIM    = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [5:0]            rows_i,
  input  logic [5:0]            cols_i,
  input  logic [ELEM_WIDTH-1:0] min_val_i,
  input  logic [ELEM_WIDTH-1:0] max_val_i,
  input  logic [31:0]           rand_in_i [NUM_LANES],
  output logic                  rng_next_o,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [5:0]            wr_row_o,
  output logic [5:0]            wr_col_o,
  output logic [ELEM_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);
  localparam int EW = ELEM_WIDTH;
  localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  typedef enum logic [2:0] {IDLE, CHECK, LOAD, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [5:0] rows_q, rows_d, cols_q, cols_d, row_q, row_d, col_q, col_d;
  logic [EW-1:0] min_q, min_d, max_q, max_d, data_q, data_d;
  logic [EW-1:0] buf_q [NUM_LANES];
  logic [EW-1:0] buf_d [NUM_LANES];
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0] lane_q, lane_d, lane_n;
  logic [EW:0] span;
  logic bad, last, col_wrap;
  logic [NUM_LANES-1:0] unused_lo;
  // Only the top EW bits of each PRNG word feed the mapping.
  function automatic logic [EW-1:0] map_h(input logic [EW-1:0] h, input logic [EW-1:0] lo,
                                          input logic [EW:0] s);
    logic [2*EW:0] p;
    p = (2*EW+1)'(h) * (2*EW+1)'(s);
    return lo + EW'(p >> EW);
  endfunction
  always_comb for (int i = 0; i < NUM_LANES; i++) unused_lo[i] = ^rand_in_i[i][31-EW:0];
  assign span = {max_q[EW-1], max_q} - {min_q[EW-1], min_q} + {{EW{1'b0}}, 1'b1};
  assign bad = rows_q == 6'd0 || cols_q == 6'd0 || rows_q > 6'(MAX_DIM) || cols_q > 6'(MAX_DIM) ||
               $signed(min_q) > $signed(max_q);
  assign last = row_q == rows_q - 6'd1 && col_q == cols_q - 6'd1;
  assign col_wrap = col_q == cols_q - 6'd1;
  assign lane_n = lane_q + 1'b1;
  assign rng_next_o = state_q == LOAD;
  assign wr_valid_o = state_q == EMIT;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign wr_addr_o = addr_q;
  assign wr_row_o = row_q;
  assign wr_col_o = col_q;
  assign wr_data_o = data_q;
  always_comb begin
    state_d = state_q;
    rows_d = rows_q;
    cols_d = cols_q;
    min_d = min_q;
    max_d = max_q;
    buf_d = buf_q;
    lane_d = lane_q;
    row_d = row_q;
    col_d = col_q;
    addr_d = addr_q;
    data_d = data_q;
    err_o = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = CHECK;
        rows_d = rows_i;
        cols_d = cols_i;
        min_d = min_val_i;
        max_d = max_val_i;
        row_d = '0;
        col_d = '0;
        addr_d = '0;
      end
      CHECK: begin
        err_o = bad;
        state_d = bad ? IDLE : LOAD;
      end
      LOAD: begin
        for (int i = 0; i < NUM_LANES; i++) buf_d[i] = rand_in_i[i][31 -: EW];
        lane_d = '0;
        data_d = map_h(rand_in_i[0][31 -: EW], min_q, span);
        state_d = EMIT;
      end
      EMIT: if (wr_ready_i) begin
        if (last) state_d = DONE;
        else begin
          col_d = col_wrap ? 6'd0 : col_q + 6'd1;
          row_d = col_wrap ? row_q + 6'd1 : row_q;
          addr_d = addr_q + 1'b1;
          lane_d = lane_n;
          // Refetch once the buffered lanes are used up; otherwise present the next lane now.
          if (lane_q == LW'(NUM_LANES - 1)) state_d = LOAD;
          else data_d = map_h(buf_q[lane_n], min_q, span);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rows_q <= '0;
      cols_q <= '0;
      min_q <= '0;
      max_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) buf_q[i] <= '0;
      lane_q <= '0;
      row_q <= '0;
      col_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      rows_q <= rows_d;
      cols_q <= cols_d;
      min_q <= min_d;
      max_q <= max_d;
      buf_q <= buf_d;
      lane_q <= lane_d;
      row_q <= row_d;
      col_q <= col_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_xorshift_matrix_filler.sv
// tb_xorshift_matrix_filler: scoreboard bench; expected elements are queued when the PRNG words
// are consumed and popped on each write handshake.
module tb_xorshift_matrix_filler;
  localparam int NL = 4;
  localparam int EW = 16;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic rst_n, start_i, wr_ready_i;
  logic [5:0] rows_i, cols_i;
  logic [EW-1:0] min_val_i, max_val_i;
  logic [31:0] rand_in_i [NL];
  logic rng_next_o, wr_valid_o, busy_o, done_o, err_o;
  logic [AW-1:0] wr_addr_o;
  logic [5:0] wr_row_o, wr_col_o;
  logic [EW-1:0] wr_data_o;

  xorshift_matrix_filler #(.NUM_LANES(NL), .ELEM_WIDTH(EW), .MAX_DIM(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .rows_i(rows_i), .cols_i(cols_i),
    .min_val_i(min_val_i), .max_val_i(max_val_i), .rand_in_i(rand_in_i), .rng_next_o(rng_next_o),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o), .wr_row_o(wr_row_o),
    .wr_col_o(wr_col_o), .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [5:0]    row;
    logic [5:0]    col;
    logic [EW-1:0] data;
  } elem_t;

  elem_t sb[$];
  logic [EW-1:0] obs_data[$];
  int checks = 0, errors = 0, cyc = 0;
  int total = 0, pushed = 0, cur_cols = 1, cur_min = 0, cur_max = 0;
  int writes, rng_cnt, done_cnt, err_cnt, valid_cnt, first_valid, last_wr, done_cyc, err_cyc, start_cyc;
  logic stall_prev = 1'b0;
  logic [38:0] snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({wr_valid_o, rng_next_o, busy_o, done_o, err_o, wr_addr_o, wr_row_o, wr_col_o, wr_data_o});
  endfunction

  function automatic logic [EW-1:0] exp_map(input int mn, input int mx, input logic [31:0] w);
    longint span, off;
    span = longint'(mx) - longint'(mn) + 1;
    off = (longint'(w[31:16]) * span) / 65536;
    return EW'(longint'(mn) + off);
  endfunction

  task automatic tick();
    logic new_words;
    elem_t e;
    new_words = 1'b0;
    @(negedge clk);
    cyc++;
    if (stall_prev) chk("hold", 64'({wr_valid_o, wr_addr_o, wr_row_o, wr_col_o, wr_data_o}), 64'(snap));
    if (rng_next_o) begin
      rng_cnt++;
      new_words = 1'b1;
      for (int i = 0; i < NL; i++)
        if (pushed < total) begin
          sb.push_back('{addr: AW'(pushed), row: 6'(pushed / cur_cols), col: 6'(pushed % cur_cols),
                         data: exp_map(cur_min, cur_max, rand_in_i[i])});
          pushed++;
        end
    end
    if (wr_valid_o) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (wr_valid_o && wr_ready_i) begin
      writes++;
      last_wr = cyc;
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk("elem", 64'({wr_addr_o, wr_row_o, wr_col_o, wr_data_o}), 64'(e));
        obs_data.push_back(wr_data_o);
      end
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_o) begin
      err_cnt++;
      err_cyc = cyc;
    end
    stall_prev = wr_valid_o && !wr_ready_i;
    snap = {wr_valid_o, wr_addr_o, wr_row_o, wr_col_o, wr_data_o};
    @(posedge clk);
    #1;
    if (new_words) for (int i = 0; i < NL; i++) rand_in_i[i] = $urandom();
  endtask

  task automatic launch(input int r, input int c, input int mn, input int mx);
    rows_i = 6'(r);
    cols_i = 6'(c);
    min_val_i = EW'(mn);
    max_val_i = EW'(mx);
    cur_cols = c == 0 ? 1 : c;
    cur_min = mn;
    cur_max = mx;
    total = r * c;
    pushed = 0;
    writes = 0; rng_cnt = 0; done_cnt = 0; err_cnt = 0; valid_cnt = 0;
    first_valid = -1; last_wr = 0; done_cyc = 0; err_cyc = 0;
    obs_data.delete();
    stall_prev = 1'b0;
    start_i = 1'b1;
    start_cyc = cyc + 1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_fill(input int r, input int c, input int mn, input int mx, input logic [3:0] pat);
    launch(r, c, mn, mx);
    for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
      wr_ready_i = pat[n % 4];
      tick();
    end
    wr_ready_i = 1'b1;
    tick();
    tick();
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("writes", 64'(writes), 64'(total));
    chk("sb_left", 64'(sb.size()), 64'd0);
    chk("done_lat", 64'(done_cyc - last_wr), 64'd1);
    chk("rng_pulses", 64'(rng_cnt), 64'((total + NL - 1) / NL));
    chk("start_lat", 64'(first_valid - start_cyc), 64'd3);
    chk("idle_after", 64'({busy_o, wr_valid_o}), 64'd0);
  endtask

  task automatic run_bad(input int r, input int c, input int mn, input int mx);
    launch(r, c, mn, mx);
    repeat (5) tick();
    chk("err_pulses", 64'(err_cnt), 64'd1);
    chk("err_lat", 64'(err_cyc - start_cyc), 64'd1);
    chk("err_no_valid", 64'(valid_cnt), 64'd0);
    chk("err_idle", 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    wr_ready_i = 1'b1;
    rows_i = 6'd1;
    cols_i = 6'd1;
    min_val_i = '0;
    max_val_i = '0;
    for (int i = 0; i < NL; i++) rand_in_i[i] = $urandom();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    run_fill(2, 3, 5, 5, 4'b1111);
    run_fill(3, 3, -1000, 1000, 4'b1111);
    rand_in_i = '{32'h00001234, 32'h8000ABCD, 32'hFFFF0000, 32'h12345678};
    run_fill(1, 3, -10, 10, 4'b1111);
    chk("map_lo", 64'(obs_data[0]), 64'(16'hFFF6));
    chk("map_mid", 64'(obs_data[1]), 64'(16'h0000));
    chk("map_hi", 64'(obs_data[2]), 64'(16'h000A));
    run_fill(3, 5, -32768, 32767, 4'b1001);
    run_fill(32, 32, -7, 300, 4'b1011);
    run_bad(0, 4, 0, 1);
    run_bad(2, 33, 0, 1);
    run_bad(2, 2, 4, 3);
    launch(4, 4, -100, 100);
    for (int n = 0; n < 100 && !(writes >= 5 && wr_valid_o); n++) tick();
    chk("mid_emit", 64'(wr_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", outs(), 64'd0);
    sb.delete();
    stall_prev = 1'b0;
    tick();
    chk("rst_hold", outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_idle", 64'(busy_o), 64'd0);
    run_fill(2, 2, -3, 3, 4'b1111);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
